// File: rtl/perceptron_neuron.sv
// -----------------------------------------------------------------------------
// perceptron_neuron
//
// A single perceptron neuron that works one input at a time. Each accepted
// input beat adds w[i]*x[i] to an accumulator. The accumulator starts from the
// bias. After N_INPUTS beats the neuron presents the bipolar decision and the
// raw sum on a valid/ready output. When training is requested and the decision
// is wrong, the neuron applies the perceptron rule to its own weight and bias
// registers over N_INPUTS+1 cycles. It then returns to accumulating.
//
// Ports
//   clk        rising-edge clock
//   r          asynchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   neuron accepts an input beat
//   in_data    signed input sample x[i], presented in index order
//   train_en   training request, sampled on beat 0
//   target     desired class (1 = +1, 0 = -1), sampled on beat 0
//   w_we       weight write strobe (honoured only between vectors)
//   w_addr     weight index; index N_INPUTS addresses the bias
//   w_wdata    signed weight/bias value to write
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_y      decision: 1 when out_acc >= 0
//   out_acc    signed weighted sum including bias
//   busy       vector in flight, result pending, or update running
// -----------------------------------------------------------------------------
module perceptron_neuron #(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = 8,
    parameter int W_W      = 8,
    parameter int ACC_W    = 20
) (
    input  logic                             clk,
    input  logic                             r,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                in_data,
    input  logic                             train_en,
    input  logic                             target,
    input  logic                             w_we,
    input  logic [$clog2(N_INPUTS+1)-1:0]    w_addr,
    input  logic [W_W-1:0]                   w_wdata,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_y,
    output logic [ACC_W-1:0]                 out_acc,
    output logic                             busy
);

    localparam int AW = $clog2(N_INPUTS + 1);   // weight address / update counter width
    localparam int IW = $clog2(N_INPUTS);       // beat counter / array index width
    localparam int PW = DATA_W + W_W;           // full product width
    localparam int SW = ((W_W > DATA_W) ? W_W : DATA_W) + 2;  // update sum width

    localparam logic [IW-1:0] CNT_LAST  = IW'(N_INPUTS - 1);
    localparam logic [IW-1:0] CNT_ONE   = IW'(1);
    localparam logic [IW-1:0] CNT_ZERO  = IW'(0);
    localparam logic [AW-1:0] UCNT_LAST = AW'(N_INPUTS);
    localparam logic [AW-1:0] UCNT_ONE  = AW'(1);
    localparam logic [AW-1:0] UCNT_ZERO = AW'(0);

    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (W_W - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;   // -(2^(W_W-1))
    localparam logic signed [SW-1:0] ONE_SW  = SW'(1);

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_RESULT = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    // Clamp a widened update sum back into the signed weight range.
    function automatic logic [W_W-1:0] sat_w(input logic signed [SW-1:0] v);
        logic [W_W-1:0] res;
        if (v > SAT_MAX) begin
            res = SAT_MAX[W_W-1:0];
        end else if (v < SAT_MIN) begin
            res = SAT_MIN[W_W-1:0];
        end else begin
            res = v[W_W-1:0];
        end
        return res;
    endfunction

    state_t                   state_q, state_d;
    logic [IW-1:0]            cnt_q, cnt_d;
    logic [AW-1:0]            ucnt_q, ucnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     train_q, train_d;
    logic                     target_q, target_d;
    logic signed [W_W-1:0]    w_q [N_INPUTS];
    logic signed [W_W-1:0]    bias_q;
    logic signed [DATA_W-1:0] xbuf_q [N_INPUTS];

    logic                     in_ready_s;
    logic                     beat_s;
    logic                     wr_s;
    logic                     y_s;
    logic signed [DATA_W-1:0] x_s;
    logic signed [W_W-1:0]    w_cur_s;
    logic signed [PW-1:0]     x_ext_s;
    logic signed [PW-1:0]     w_ext_s;
    logic signed [PW-1:0]     prod_s;
    logic signed [ACC_W-1:0]  prod_acc_s;
    logic signed [ACC_W-1:0]  bias_acc_s;
    logic [IW-1:0]            uidx_s;
    logic signed [SW-1:0]     w_upd_ext_s;
    logic signed [SW-1:0]     x_upd_ext_s;
    logic signed [SW-1:0]     bias_upd_ext_s;
    logic [W_W-1:0]           w_upd_s;
    logic [W_W-1:0]           bias_upd_s;

    assign x_s     = in_data;
    assign w_cur_s = w_q[cnt_q];

    // Both operands are sign-extended to the full product width, so the low PW
    // bits of the multiply are the exact signed product.
    assign x_ext_s    = {{(PW - DATA_W){x_s[DATA_W-1]}}, x_s};
    assign w_ext_s    = {{(PW - W_W){w_cur_s[W_W-1]}}, w_cur_s};
    assign prod_s     = x_ext_s * w_ext_s;
    assign prod_acc_s = {{(ACC_W - PW){prod_s[PW-1]}}, prod_s};
    assign bias_acc_s = {{(ACC_W - W_W){bias_q[W_W-1]}}, bias_q};

    // Perceptron rule operands: w[k] +/- x[k], bias +/- 1, all in a widened domain.
    assign uidx_s         = ucnt_q[IW-1:0];
    assign w_upd_ext_s    = {{(SW - W_W){w_q[uidx_s][W_W-1]}}, w_q[uidx_s]};
    assign x_upd_ext_s    = {{(SW - DATA_W){xbuf_q[uidx_s][DATA_W-1]}}, xbuf_q[uidx_s]};
    assign bias_upd_ext_s = {{(SW - W_W){bias_q[W_W-1]}}, bias_q};
    assign w_upd_s        = sat_w(target_q ? (w_upd_ext_s + x_upd_ext_s)
                                           : (w_upd_ext_s - x_upd_ext_s));
    assign bias_upd_s     = sat_w(target_q ? (bias_upd_ext_s + ONE_SW)
                                           : (bias_upd_ext_s - ONE_SW));

    // A weight write steals the cycle from the input stream, so in_ready drops with w_we.
    assign in_ready_s = (state_q == ST_ACCUM) && !w_we;
    assign beat_s     = in_valid && in_ready_s;
    assign wr_s       = w_we && (state_q == ST_ACCUM) && (cnt_q == CNT_ZERO)
                        && (w_addr <= UCNT_LAST);
    assign y_s        = ~acc_q[ACC_W-1];

    // Output decode. in_ready is also masked by the reset input itself, so it
    // drops in the same instant that reset is asserted.
    assign in_ready  = in_ready_s && !r;
    assign out_valid = (state_q == ST_RESULT);
    assign out_y     = (state_q == ST_RESULT) && y_s;
    assign out_acc   = (state_q == ST_RESULT) ? acc_q : {ACC_W{1'b0}};
    assign busy      = (state_q == ST_RESULT) || (state_q == ST_UPDATE)
                       || ((state_q == ST_ACCUM) && (cnt_q != CNT_ZERO));

    // Next-state and datapath control for accumulation, result and update phases.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ucnt_d   = ucnt_q;
        acc_d    = acc_q;
        train_d  = train_q;
        target_d = target_q;
        case (state_q)
            ST_ACCUM: begin
                if (beat_s) begin
                    if (cnt_q == CNT_ZERO) begin
                        acc_d    = bias_acc_s + prod_acc_s;
                        train_d  = train_en;
                        target_d = target;
                    end else begin
                        acc_d    = acc_q + prod_acc_s;
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = CNT_ZERO;
                        state_d = ST_RESULT;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RESULT: begin
                if (out_ready) begin
                    if (train_q && (y_s != target_q)) begin
                        ucnt_d  = UCNT_ZERO;
                        state_d = ST_UPDATE;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_RESULT;
                end
            end
            ST_UPDATE: begin
                if (ucnt_q == UCNT_LAST) begin
                    ucnt_d  = UCNT_ZERO;
                    state_d = ST_ACCUM;
                end else begin
                    ucnt_d  = ucnt_q + UCNT_ONE;
                end
            end
            default: begin
                state_d = ST_ACCUM;
                cnt_d   = CNT_ZERO;
                ucnt_d  = UCNT_ZERO;
            end
        endcase
    end

    // Control and accumulator registers.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q  <= ST_ACCUM;
            cnt_q    <= CNT_ZERO;
            ucnt_q   <= UCNT_ZERO;
            acc_q    <= {ACC_W{1'b0}};
            train_q  <= 1'b0;
            target_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ucnt_q   <= ucnt_d;
            acc_q    <= acc_d;
            train_q  <= train_d;
            target_q <= target_d;
        end
    end

    // Input sample buffer, kept for the training update.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                xbuf_q[i] <= {DATA_W{1'b0}};
            end
        end else if (beat_s) begin
            xbuf_q[cnt_q] <= x_s;
        end
    end

    // Weight and bias storage. External writes are only possible between
    // vectors, so they never collide with a training update.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                w_q[i] <= {W_W{1'b0}};
            end
            bias_q <= {W_W{1'b0}};
        end else if (wr_s) begin
            if (w_addr == UCNT_LAST) begin
                bias_q <= w_wdata;
            end else begin
                w_q[w_addr[IW-1:0]] <= w_wdata;
            end
        end else if (state_q == ST_UPDATE) begin
            if (ucnt_q == UCNT_LAST) begin
                bias_q <= bias_upd_s;
            end else begin
                w_q[uidx_s] <= w_upd_s;
            end
        end
    end

endmodule

// File: tb/tb_perceptron_neuron.sv
module tb_perceptron_neuron;

    logic        clk = 1'b0;
    logic        r;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        train_en;
    logic        target;
    logic        w_we;
    logic [2:0]  w_addr;
    logic [7:0]  w_wdata;
    logic        out_valid;
    logic        out_ready;
    logic        out_y;
    logic [19:0] out_acc;
    logic        busy;

    logic [20:0] exp_q [$];
    logic [20:0] mon_e;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    perceptron_neuron #(
        .N_INPUTS(4), .DATA_W(8), .W_W(8), .ACC_W(20)
    ) dut (
        .clk(clk), .r(r), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .train_en(train_en), .target(target),
        .w_we(w_we), .w_addr(w_addr), .w_wdata(w_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_acc(out_acc), .busy(busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expected result per output handshake
    always @(negedge clk) begin
        if (!r && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_y", int'(out_y), int'(mon_e[20]));
                chk("out_acc", int'($signed(out_acc)), int'($signed(mon_e[19:0])));
            end
        end
    end

    task automatic expect_res(input int acc);
        logic [19:0] a;
        a = 20'(acc);
        exp_q.push_back({(acc >= 0) ? 1'b1 : 1'b0, a});
    endtask

    task automatic beat(input int d, input logic tr, input logic tg);
        int   n;
        logic ok;
        n = 0;
        in_valid = 1'b1;
        in_data  = 8'(d);
        train_en = tr;
        target   = tg;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) chk("beat_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input int a, input int b, input int c, input int d,
                            input logic tr, input logic tg, input int acc);
        expect_res(acc);
        beat(a, tr, tg);
        beat(b, tr, tg);
        beat(c, tr, tg);
        beat(d, tr, tg);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input int addr, input int val);
        w_we    = 1'b1;
        w_addr  = 3'(addr);
        w_wdata = 8'(val);
        @(posedge clk);
        #1;
        w_we    = 1'b0;
    endtask

    initial begin
        int n;
        r = 1'b1; in_valid = 1'b0; in_data = 8'd0; train_en = 1'b0; target = 1'b0;
        w_we = 1'b0; w_addr = 3'd0; w_wdata = 8'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_y", int'(out_y), 0);
        chk("rst_out_acc", int'(out_acc), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        r = 1'b0;

        // Post-reset inference: all-zero weights
        send_vec(1, 2, 3, 4, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("latency_out_valid", int'(out_valid), 1);
        wait_idle();

        // Loaded weights
        write_w(0, 1); write_w(1, -2); write_w(2, 3); write_w(3, -4); write_w(4, 5);
        send_vec(10, 10, 10, 10, 1'b0, 1'b0, -15);
        @(negedge clk);
        @(negedge clk);
        chk("no_update_in_ready", int'(in_ready), 1);
        chk("no_update_busy", int'(busy), 0);
        @(posedge clk);
        #1;

        // Training on error: weights -> {11,8,13,6}, bias 6
        send_vec(10, 10, 10, 10, 1'b1, 1'b1, -15);
        @(negedge clk);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("update_cycles", n, 5);
        @(posedge clk);
        #1;
        send_vec(10, 10, 10, 10, 1'b0, 1'b0, 386);
        wait_idle();

        // Training vector already classified correctly: no update
        send_vec(10, 10, 10, 10, 1'b1, 1'b1, 386);
        @(negedge clk);
        @(negedge clk);
        chk("correct_no_update", int'(in_ready), 1);
        @(posedge clk);
        #1;
        send_vec(1, 0, 0, 0, 1'b0, 1'b0, 17);
        wait_idle();

        // Saturation: weights -> {127,-28,-28,-28}, bias -127
        write_w(0, 100); write_w(1, -128); write_w(2, -128); write_w(3, -128); write_w(4, -128);
        send_vec(100, 100, 100, 100, 1'b1, 1'b1, -28528);
        wait_idle();
        send_vec(1, 2, 3, 4, 1'b0, 1'b0, -252);
        wait_idle();

        // Out-of-range address ignored: bias stays -127
        write_w(5, 50);
        send_vec(0, 0, 0, 0, 1'b0, 1'b0, -127);
        wait_idle();

        // Backpressure with an illegal write during RESULT
        out_ready = 1'b0;
        send_vec(1, 1, 1, 1, 1'b0, 1'b0, -84);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_acc", int'($signed(out_acc)), -84);
            chk("bp_out_y", int'(out_y), 0);
            chk("bp_in_ready", int'(in_ready), 0);
            @(posedge clk);
            #1;
            w_we = (i == 1) ? 1'b1 : 1'b0;
            w_addr = 3'd0;
            w_wdata = 8'd0;
        end
        w_we = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Mid-vector write at cnt=2 is ignored
        expect_res(-84);
        beat(1, 1'b0, 1'b0);
        beat(1, 1'b0, 1'b0);
        w_we = 1'b1; w_addr = 3'd3; w_wdata = 8'd0;
        @(posedge clk);
        #1;
        w_we = 1'b0;
        beat(1, 1'b0, 1'b0);
        beat(1, 1'b0, 1'b0);
        wait_idle();
        send_vec(1, 0, 0, 0, 1'b0, 1'b0, 0);
        wait_idle();

        // Reset during UPDATE cycle 2
        send_vec(0, 0, 0, 0, 1'b1, 1'b1, -127);
        repeat (3) @(posedge clk);
        #2;
        chk("busy_in_update", int'(busy), 1);
        r = 1'b1;
        #1;
        chk("rst_mid_out_valid", int'(out_valid), 0);
        chk("rst_mid_in_ready", int'(in_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        r = 1'b0;
        send_vec(5, 5, 5, 5, 1'b0, 1'b0, 0);
        wait_idle();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/perceptron_neuron.md
Name: perceptron_neuron

Overview:
- Sequential single-neuron stage of the single-layer perceptron.
- Consumes one signed input sample per accepted beat and accumulates weight*input, starting from a bias term.
- After N_INPUTS beats, presents the bipolar decision and the raw sum on a valid/ready output.
- In training mode, applies the perceptron rule to its internal weight and bias registers when the decision is wrong, then returns for the next vector.

Parameters:
- N_INPUTS, 4: inputs per vector (>=2).
- DATA_W, 8: signed input width.
- W_W, 8: signed weight and bias width.
- ACC_W, 20: signed accumulator width. Must be >= DATA_W+W_W+clog2(N_INPUTS+1). No overflow handling beyond this.

Ports:
- clk  in  1  rising-edge clock.
- r  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  neuron accepts an input beat.
- in_data  in  DATA_W  signed input sample x[i], presented in index order 0..N_INPUTS-1.
- train_en  in  1  training request; sampled on beat 0 of a vector.
- target  in  1  desired class (1 = +1, 0 = -1); sampled on beat 0.
- w_we  in  1  weight write strobe.
- w_addr  in  clog2(N_INPUTS+1)  weight index; index N_INPUTS addresses the bias.
- w_wdata  in  W_W  signed value to write.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_y  out  1  decision: 1 if out_acc >= 0, else 0.
- out_acc  out  ACC_W  signed weighted sum including bias.
- busy  out  1  high in RESULT or UPDATE, or in ACCUM with cnt != 0.

Behaviour:
- Async reset clears everything: state=ACCUM, cnt=0, acc=0, all weights and bias=0, input buffer=0, latched train/target=0. Outputs during reset: out_valid=0, out_y=0, out_acc=0, in_ready=0.
- State ACCUM:
  - in_ready = !w_we.
  - On beat accept: xbuf[cnt] <= in_data; acc <= (cnt==0 ? sext(bias) : acc) + w[cnt]*in_data, full signed product sign-extended to ACC_W; cnt++.
  - Beat 0 also latches train_en and target.
  - The beat with cnt==N_INPUTS-1 sets cnt=0 and moves to RESULT.
- State RESULT:
  - out_valid=1; out_acc=acc; out_y=~acc[ACC_W-1]. Latency: out_valid rises on the cycle after the last beat is accepted.
  - Outputs are held stable while out_ready=0. in_ready=0.
  - On out_valid&out_ready: if latched train=1 and out_y != target, go to UPDATE with ucnt=0; otherwise go to ACCUM.
- State UPDATE:
  - Lasts N_INPUTS+1 cycles; in_ready=0, out_valid=0.
  - Cycle k<N_INPUTS: w[k] <= sat(w[k] + (target ? xbuf[k] : -xbuf[k])).
  - Cycle N_INPUTS: bias <= sat(bias + (target ? 1 : -1)). Then go to ACCUM.
  - sat clamps to [-2^(W_W-1), 2^(W_W-1)-1]. Intermediate sum width is max(W_W,DATA_W)+2.
- Weight writes:
  - w_we is honoured only in ACCUM with cnt==0. It is ignored in all other states and mid-vector.
  - Writes complete in one cycle; the new value is used from the next accepted beat.
  - w_we has priority over an input beat because in_ready is low that cycle. w_addr > N_INPUTS is ignored.
- Result ordering: out_acc/out_y always reflect the weights in effect before the update triggered by that same result.
- Reset mid-operation (any state) aborts immediately: partial accumulation and any in-progress update are discarded, and weights return to 0.

Test Plan:
- Post-reset inference: x={1,2,3,4}, train_en=0 -> out_acc=0, out_y=1. out_valid rises exactly 1 cycle after 4th beat; weights unchanged.
- Loaded weights: write w={1,-2,3,-4}, bias=5; x={10,10,10,10}, train_en=0 -> out_acc=-15, out_y=0; no UPDATE entered; next vector accepted immediately after the handshake.
- Training on error: same weights, x={10,10,10,10}, train_en=1, target=1 -> result out_acc=-15, out_y=0. Then 5 UPDATE cycles with in_ready=0. Weights become {11,8,13,6}, bias=6. Re-run inference on the same vector -> out_acc=386, out_y=1. A training vector with correct decision -> no UPDATE.
- Saturation: w={100,-128,-128,-128}, bias=-128; x={100,100,100,100}, train_en=1, target=1 -> out_y=0. Weights become {127,-28,-28,-28}, bias=-127.
- Backpressure and illegal write: hold out_ready=0 for 5 cycles in RESULT -> out_valid, out_acc, out_y stable and in_ready=0. A w_we pulse during RESULT or mid-vector (cnt=2) leaves weights unchanged.
- Async reset during UPDATE cycle 2 -> same-instant out_valid=0, in_ready=0. After release: all weights 0, and x={5,5,5,5} yields out_acc=0.
